qmr_fault_manager: RTL and testbench

Sequential supervisor for the quintuple-redundant ALU in the execute stage. Consumes the per-ALU vote counts on every valid ALU operation and keeps a leaky-bucket error counter per ALU. Permanently masks ALUs that keep disagreeing with the majority. Requests pipeline stall/retry when no majority exists and raises a sticky fatal flag when redundancy is exhausted.

---
 rtl/qmr_pkg.sv | 21 ++
 rtl/qmr_err_counter.sv | 38 +++
 rtl/qmr_fault_manager.sv | 140 ++++++++++++++
 tb/tb_qmr_fault_manager.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/qmr_pkg.sv
// Shared constants, FSM encoding and helpers for the quintuple-redundant ALU fault manager.
// Combinational definitions only; no latency, no backpressure.
package qmr_pkg;
    localparam int NUM_ALUS      = 5;
    localparam int VOTE_W        = 3;
    localparam int MAJ_MIN_AGREE = 2;
    localparam int MAJ_MIN_ALUS  = 3;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        RETRY  = 2'b01,
        FATAL  = 2'b10
    } qmr_state_e;

    function automatic logic [2:0] popcnt5(input logic [NUM_ALUS-1:0] v);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < NUM_ALUS; i++) s = s + {2'b00, v[i]};
        return s;
    endfunction
endpackage

// File: rtl/qmr_err_counter.sv
// Per-ALU leaky-bucket error counter with a sticky mask bit once the threshold is reached.
// Counter updates on the edge after inc/dec; mask sets one edge after the counter reaches threshold.
// No backpressure; the counter freezes once the ALU is masked.
module qmr_err_counter #(
    parameter int CNT_W      = 4,
    parameter int ERR_THRESH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             masked
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ERR_THRESH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            masked <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            masked <= 1'b0;
        end else begin
            if (cnt >= THRESH) masked <= 1'b1;
            // increment wins over a coincident decay tick
            if (!masked) begin
                if (inc) begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                end else if (dec && cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/qmr_fault_manager.sv
// Supervisor for the 5-way redundant ALU: error bucketing, masking, retry/stall FSM, fatal flag.
// All outputs registered, one cycle after the sampled op; stall_o holds execute while not NORMAL.
// Optional statistics counters enabled by QMR_STATS_EN.
module qmr_fault_manager
    import qmr_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int ERR_THRESH   = 8,
    parameter int DECAY_PERIOD = 1024,
    parameter int MAX_RETRY    = 2,
    parameter int STAT_W       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid_i,
    input  logic [NUM_ALUS*VOTE_W-1:0] vote_count_i,
    input  logic                      clear_i,
    output logic [NUM_ALUS-1:0]       alu_mask_o,
    output logic [NUM_ALUS*CNT_W-1:0] err_cnt_o,
    output logic                      retry_req_o,
    output logic                      stall_o,
    output logic                      fatal_o,
    output logic [1:0]                state_o,
    output logic [STAT_W-1:0]         disagree_total_o,
    output logic [STAT_W-1:0]         nomaj_total_o
);
    localparam logic [1:0] S_NORMAL = NORMAL;
    localparam logic [1:0] S_RETRY  = RETRY;
    localparam logic [1:0] S_FATAL  = FATAL;
    localparam int TMR_W = $clog2(DECAY_PERIOD);
    localparam int RC_W  = $clog2(MAX_RETRY + 1);
    // fewer than MAJ_MIN_ALUS live ALUs can no longer form a majority
    localparam logic [2:0] FATAL_MASKS = 3'(NUM_ALUS - MAJ_MIN_ALUS + 1);

    logic [NUM_ALUS-1:0] agree, mask, err_evt;
    logic                majority_ok, upd_en, decay_wrap, force_fatal, go_retry;
    logic [TMR_W-1:0]    decay_tmr;
    logic [1:0]          state;
    logic [RC_W-1:0]     retry_cnt;
    logic                retry_req;

    always_comb begin
        agree = '0;
        for (int i = 0; i < NUM_ALUS; i++)
            agree[i] = vote_count_i[VOTE_W*i +: VOTE_W] >= VOTE_W'(MAJ_MIN_AGREE);
    end

    assign majority_ok = popcnt5(agree & ~mask) >= 3'(MAJ_MIN_ALUS);
    assign upd_en      = (state == S_NORMAL);
    assign err_evt     = {NUM_ALUS{op_valid_i & majority_ok & upd_en}} & ~mask & ~agree;
    assign decay_wrap  = (decay_tmr == TMR_W'(DECAY_PERIOD - 1));
    assign force_fatal = popcnt5(mask) >= FATAL_MASKS;
    assign go_retry    = upd_en & op_valid_i & ~majority_ok & ~force_fatal & ~clear_i;

    for (genvar g = 0; g < NUM_ALUS; g++) begin : g_cnt
        qmr_err_counter #(.CNT_W(CNT_W), .ERR_THRESH(ERR_THRESH)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear_i),
            .inc    (err_evt[g]),
            .dec    (decay_wrap & upd_en),
            .cnt    (err_cnt_o[CNT_W*g +: CNT_W]),
            .masked (mask[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        decay_tmr <= '0;
        else if (clear_i || decay_wrap)   decay_tmr <= '0;
        else                              decay_tmr <= decay_tmr + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_NORMAL;
            retry_cnt <= '0;
            retry_req <= 1'b0;
        end else begin
            retry_req <= 1'b0;
            if (clear_i) begin
                state     <= S_NORMAL;
                retry_cnt <= '0;
            end else if (force_fatal) begin
                state <= S_FATAL;
            end else begin
                case (state)
                    S_NORMAL: if (go_retry) begin
                        state     <= S_RETRY;
                        retry_cnt <= RC_W'(1);
                        retry_req <= 1'b1;
                    end
                    S_RETRY: if (op_valid_i) begin
                        if (majority_ok) begin
                            state     <= S_NORMAL;
                            retry_cnt <= '0;
                        end else if (retry_cnt < RC_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            retry_req <= 1'b1;
                        end else begin
                            state <= S_FATAL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign alu_mask_o  = mask;
    assign retry_req_o = retry_req;
    assign state_o     = state;
    assign stall_o     = (state != S_NORMAL);
    assign fatal_o     = (state == S_FATAL);

`ifdef QMR_STATS_EN
    logic [STAT_W-1:0] dis_tot, nomaj_tot;
    logic [STAT_W:0]   dis_sum;

    assign dis_sum = {1'b0, dis_tot} + (STAT_W+1)'(popcnt5(err_evt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dis_tot   <= '0;
            nomaj_tot <= '0;
        end else if (clear_i) begin
            dis_tot   <= '0;
            nomaj_tot <= '0;
        end else begin
            dis_tot <= dis_sum[STAT_W] ? '1 : dis_sum[STAT_W-1:0];
            if (go_retry && nomaj_tot != '1) nomaj_tot <= nomaj_tot + 1'b1;
        end
    end

    assign disagree_total_o = dis_tot;
    assign nomaj_total_o    = nomaj_tot;
`else
    assign disagree_total_o = '0;
    assign nomaj_total_o    = '0;
`endif
endmodule

// File: tb/tb_qmr_fault_manager.sv
// Directed bench for qmr_fault_manager with hand-computed expectations.
module tb_qmr_fault_manager;
    localparam int CNT_W = 4, ERR_THRESH = 8, DP = 1024, MAX_RETRY = 2, STAT_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                op_valid_i;
    logic [14:0]         vote_count_i;
    logic                clear_i;
    logic [4:0]          alu_mask_o;
    logic [5*CNT_W-1:0]  err_cnt_o;
    logic                retry_req_o, stall_o, fatal_o;
    logic [1:0]          state_o;
    logic [STAT_W-1:0]   disagree_total_o, nomaj_total_o;

    int n_cmp = 0;
    int n_bad = 0;

    qmr_fault_manager #(
        .CNT_W(CNT_W), .ERR_THRESH(ERR_THRESH), .DECAY_PERIOD(DP),
        .MAX_RETRY(MAX_RETRY), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset), .op_valid_i(op_valid_i), .vote_count_i(vote_count_i),
        .clear_i(clear_i), .alu_mask_o(alu_mask_o), .err_cnt_o(err_cnt_o),
        .retry_req_o(retry_req_o), .stall_o(stall_o), .fatal_o(fatal_o), .state_o(state_o),
        .disagree_total_o(disagree_total_o), .nomaj_total_o(nomaj_total_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [14:0] v, input int n);
        op_valid_i   = 1'b1;
        vote_count_i = v;
        tick(n);
        op_valid_i   = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    function automatic logic [14:0] votes(input logic [2:0] v4, v3, v2, v1, v0);
        return {v4, v3, v2, v1, v0};
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(err_cnt_o[CNT_W*i +: CNT_W]);
    endfunction

    initial begin
        int stats_on;
`ifdef QMR_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        reset = 1'b1; op_valid_i = 1'b0; vote_count_i = '0; clear_i = 1'b0;
        #12;
        chk("rst_mask",  32'(alu_mask_o), 0);
        chk("rst_cnt",   32'(err_cnt_o), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_retry", 32'(retry_req_o), 0);
        chk("rst_fatal", 32'(fatal_o), 0);
        chk("rst_dis",   disagree_total_o, 0);
        chk("rst_nomaj", nomaj_total_o, 0);
        reset = 1'b0;
        tick(1);

        // clean votes
        op(votes(4, 4, 4, 4, 4), 100);
        chk("clean_cnt",   32'(err_cnt_o), 0);
        chk("clean_mask",  32'(alu_mask_o), 0);
        chk("clean_state", 32'(state_o), 0);
        chk("clean_stall", 32'(stall_o), 0);

        // ALU2 disagrees eight times, mask follows a cycle later
        do_clear();
        op(votes(3, 3, 0, 3, 3), 8);
        chk("a2_cnt8",      cnt_of(2), 8);
        chk("a2_mask_pre",  32'(alu_mask_o), 0);
        chk("a2_dis",       disagree_total_o, stats_on ? 8 : 0);
        tick(1);
        chk("a2_mask",      32'(alu_mask_o), 32'b00100);
        chk("a2_others",    32'(err_cnt_o) & ~(32'hF << 8), 0);

        // decay of ALU1 from 3, plus increment winning over a decay tick
        do_clear();
        op(votes(4, 4, 4, 0, 4), 3);
        tick(1020);
        chk("dec_pre",  cnt_of(1), 3);
        tick(1);
        chk("dec_w1",   cnt_of(1), 2);
        tick(1024);
        chk("dec_w2",   cnt_of(1), 1);
        tick(1024);
        chk("dec_w3",   cnt_of(1), 0);
        tick(1024);
        chk("dec_w4",   cnt_of(1), 0);
        op(votes(4, 4, 4, 0, 4), 1);
        chk("dec_inc",  cnt_of(1), 1);
        tick(1022);
        chk("dec_hold", cnt_of(1), 1);
        op(votes(4, 4, 4, 0, 4), 1);
        chk("dec_coinc", cnt_of(1), 2);

        // no majority then recovery
        do_clear();
        op(votes(1, 1, 1, 1, 1), 1);
        chk("nm_retry", 32'(retry_req_o), 1);
        chk("nm_stall", 32'(stall_o), 1);
        chk("nm_state", 32'(state_o), 1);
        tick(1);
        chk("nm_pulse", 32'(retry_req_o), 0);
        chk("nm_hold",  32'(state_o), 1);
        op(votes(4, 4, 4, 4, 4), 1);
        chk("nm_back",  32'(state_o), 0);
        chk("nm_unst",  32'(stall_o), 0);
        chk("nm_cnt",   nomaj_total_o, stats_on ? 1 : 0);

        // three consecutive no-majority ops exhaust the retries
        op(votes(1, 1, 1, 1, 1), 1);
        chk("r1_req",   32'(retry_req_o), 1);
        op(votes(1, 1, 1, 1, 1), 1);
        chk("r2_req",   32'(retry_req_o), 1);
        chk("r2_state", 32'(state_o), 1);
        op(votes(1, 1, 1, 1, 1), 1);
        chk("r3_state", 32'(state_o), 2);
        chk("r3_fatal", 32'(fatal_o), 1);
        chk("r3_req",   32'(retry_req_o), 0);
        op(votes(4, 4, 4, 4, 4), 3);
        chk("fat_stick", 32'(fatal_o), 1);
        chk("fat_stall", 32'(stall_o), 1);
        chk("fat_nomaj", nomaj_total_o, stats_on ? 2 : 0);

        // async reset mid-retry
        do_clear();
        op(votes(1, 1, 1, 1, 1), 1);
        chk("ar_pre", 32'(stall_o), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_stall", 32'(stall_o), 0);
        chk("ar_req",   32'(retry_req_o), 0);
        chk("ar_state", 32'(state_o), 0);
        #1 reset = 1'b0;
        tick(1);

        // masking ALUs 0,1,3 forces FATAL
        do_clear();
        op(votes(4, 0, 4, 4, 4), 7);
        op(votes(4, 4, 4, 0, 0), 8);
        chk("m3_c0",    cnt_of(0), 8);
        chk("m3_c3",    cnt_of(3), 7);
        op(votes(4, 0, 4, 4, 4), 1);
        chk("m3_mask2", 32'(alu_mask_o), 32'b00011);
        chk("m3_c3b",   cnt_of(3), 8);
        tick(1);
        chk("m3_mask3", 32'(alu_mask_o), 32'b01011);
        chk("m3_nofat", 32'(state_o), 0);
        tick(1);
        chk("m3_fatal", 32'(fatal_o), 1);
        chk("m3_state", 32'(state_o), 2);
        chk("m3_frz",   cnt_of(0), 8);
        do_clear();
        chk("clr_mask",  32'(alu_mask_o), 0);
        chk("clr_cnt",   32'(err_cnt_o), 0);
        chk("clr_state", 32'(state_o), 0);
        chk("clr_fatal", 32'(fatal_o), 0);
        chk("clr_dis",   disagree_total_o, 0);
        chk("clr_nomaj", nomaj_total_o, 0);

        // two disagreements in one op, then one no-majority event
        op(votes(0, 4, 4, 4, 0), 1);
        chk("st_dis2",  disagree_total_o, stats_on ? 2 : 0);
        op(votes(1, 1, 1, 1, 1), 1);
        chk("st_nomaj", nomaj_total_o, stats_on ? 1 : 0);
        chk("st_dis2b", disagree_total_o, stats_on ? 2 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
